fb_rect_writer: RTL and testbench

Pixel-producer engine that drives the write side of the `vga_double_buf` framebuffer. It accepts FILL commands (solid-colour rectangle) and PRESENT commands over a valid/ready handshake. FILL rasterises into the back buffer at one pixel per clock. PRESENT issues the `swap_buf` pulse and then stalls until the display has performed the swap at frame start. It sits between the drawing/command logic and `vga_double_buf`, in the same clock domain.

---
 rtl/fb_rect_writer_if.sv | 37 +++
 rtl/fb_rect_writer.sv | 155 +++++++++++++++
 tb/tb_fb_rect_writer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_rect_writer_if.sv
// Command and framebuffer write bundle for fb_rect_writer.
// master: command producer / memory side, slave: the engine.
interface fb_rect_writer_if #(
    parameter int RES_X      = 320,
    parameter int RES_Y      = 240,
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = $clog2(RES_X * RES_Y),
    parameter int XW         = $clog2(RES_X) + 1,
    parameter int YW         = $clog2(RES_Y) + 1
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [XW-1:0]         cmd_x;
    logic [YW-1:0]         cmd_y;
    logic [XW-1:0]         cmd_w;
    logic [YW-1:0]         cmd_h;
    logic [MEM_WIDTH-1:0]  cmd_color;
    logic                  v_sync;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]  din;
    logic                  wen;
    logic                  swap_buf;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h,
        output cmd_color, v_sync,
        input  cmd_ready, mem_addr, din, wen, swap_buf, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h,
        input  cmd_color, v_sync,
        output cmd_ready, mem_addr, din, wen, swap_buf, busy
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle fill / buffer-present engine for the write side of vga_double_buf.
// Ports: clk, rst (async active-high), bus (fb_rect_writer_if.slave):
//   cmd_valid/cmd_ready/cmd_op/cmd_x/cmd_y/cmd_w/cmd_h/cmd_color command in,
//   v_sync in, mem_addr/din/wen write out, swap_buf pulse out, busy out.
// Optional macro FB_RECT_CLIP_EN clips rectangles to the framebuffer.
module fb_rect_writer #(
    parameter int RES_X      = 320,
    parameter int RES_Y      = 240,
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = $clog2(RES_X * RES_Y),
    parameter int XW         = $clog2(RES_X) + 1,
    parameter int YW         = $clog2(RES_Y) + 1
) (
    input  logic             clk,
    input  logic             rst,
    fb_rect_writer_if.slave  bus
);
    localparam int AW = ADDR_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FILL    = 2'd1;
    localparam logic [1:0] S_SWAP    = 2'd2;
    localparam logic [1:0] S_WAIT_VS = 2'd3;

    logic [1:0]           state;
    logic                 done;
    logic                 vs_q;
    logic [XW-1:0]        x_l;
    logic [XW-1:0]        w_l;
    logic [YW-1:0]        h_l;
    logic [XW-1:0]        col;
    logic [YW-1:0]        row;
    logic [AW-1:0]        row_base;
    logic [MEM_WIDTH-1:0] color_l;

    logic                 ready_q;
    logic [AW-1:0]        addr_q;
    logic [MEM_WIDTH-1:0] din_q;
    logic                 wen_q;
    logic                 swap_q;
    logic                 busy_q;

    logic [XW-1:0]        eff_w;
    logic [YW-1:0]        eff_h;

`ifdef FB_RECT_CLIP_EN
    logic [XW-1:0] room_x;
    logic [YW-1:0] room_y;

    always_comb begin
        room_x = XW'(RES_X) - bus.cmd_x;
        room_y = YW'(RES_Y) - bus.cmd_y;
        eff_w  = (bus.cmd_w < room_x) ? bus.cmd_w : room_x;
        eff_h  = (bus.cmd_h < room_y) ? bus.cmd_h : room_y;
        if (bus.cmd_x >= XW'(RES_X) || bus.cmd_y >= YW'(RES_Y)) begin
            eff_w = '0;
            eff_h = '0;
        end
    end
`else
    assign eff_w = bus.cmd_w;
    assign eff_h = bus.cmd_h;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            vs_q     <= 1'b1;
            x_l      <= '0;
            w_l      <= '0;
            h_l      <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            color_l  <= '0;
            ready_q  <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            wen_q    <= 1'b0;
            swap_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            vs_q   <= bus.v_sync;
            wen_q  <= 1'b0;
            swap_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (!bus.cmd_op) begin
                            state    <= S_FILL;
                            done     <= 1'b0;
                            x_l      <= bus.cmd_x;
                            w_l      <= eff_w;
                            h_l      <= eff_h;
                            col      <= '0;
                            row      <= '0;
                            color_l  <= bus.cmd_color;
                            row_base <= AW'(bus.cmd_y) * AW'(RES_X);
                        end else begin
                            state <= S_SWAP;
                        end
                    end
                end
                S_FILL: begin
                    // done holds one trailing cycle so every fill,
                    // including an empty one, ends on the same edge rule.
                    if (done) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (w_l == '0 || h_l == '0) begin
                        done <= 1'b1;
                    end else begin
                        wen_q  <= 1'b1;
                        din_q  <= color_l;
                        addr_q <= row_base + AW'(x_l) + AW'(col);
                        if (col == w_l - XW'(1)) begin
                            col      <= '0;
                            row      <= row + YW'(1);
                            row_base <= row_base + AW'(RES_X);
                            if (row == h_l - YW'(1))
                                done <= 1'b1;
                        end else begin
                            col <= col + XW'(1);
                        end
                    end
                end
                S_SWAP: begin
                    swap_q <= 1'b1;
                    state  <= S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    // Only a fresh falling edge proves the swap happened.
                    if (!bus.v_sync && vs_q) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.mem_addr  = addr_q;
    assign bus.din       = din_q;
    assign bus.wen       = wen_q;
    assign bus.swap_buf  = swap_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer.
// Random and directed FILL/PRESENT commands against an address-list model.
module tb_fb_rect_writer;
    localparam int RES_X = 320;
    localparam int RES_Y = 240;
    localparam int AW    = $clog2(RES_X * RES_Y);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    fb_rect_writer_if bus ();

    fb_rect_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic model(input int x, input int y, input int w, input int h);
        int ew;
        int eh;
        ew = w;
        eh = h;
`ifdef FB_RECT_CLIP_EN
        if (x >= RES_X || y >= RES_Y) begin
            ew = 0;
            eh = 0;
        end else begin
            if (RES_X - x < ew) ew = RES_X - x;
            if (RES_Y - y < eh) eh = RES_Y - y;
        end
`endif
        exp_q.delete();
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++)
                exp_q.push_back(((y + r) * RES_X + x + c) % (1 << AW));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready got=%b exp=1", bus.cmd_ready);
        end
    endtask

    // Returns #1 after the accept edge.
    task automatic send_cmd(input bit op, input int x, input int y,
                            input int w, input int h, input int color);
        @(negedge clk);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_x     = 10'(x);
        bus.cmd_y     = 9'(y);
        bus.cmd_w     = 10'(w);
        bus.cmd_h     = 9'(h);
        bus.cmd_color = 8'(color);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_fill(input string name, input int x, input int y,
                           input int w, input int h, input int color);
        int n;
        int tail;
        model(x, y, w, h);
        n = exp_q.size();
        tail = (n == 0) ? 2 : n + 1;
        send_cmd(1'b0, x, y, w, h, color);
        for (int k = 1; k <= tail; k++) begin
            @(posedge clk);
            #1;
            if (k <= n) begin
                checks++;
                if (bus.wen !== 1'b1) begin
                    failures++;
                    $display("FAIL %s wen pix%0d got=%b exp=1", name, k, bus.wen);
                end
                checks++;
                if (bus.mem_addr !== AW'(exp_q[k-1])) begin
                    failures++;
                    $display("FAIL %s addr pix%0d got=%0d exp=%0d",
                             name, k, bus.mem_addr, exp_q[k-1]);
                end
                checks++;
                if (bus.din !== 8'(color)) begin
                    failures++;
                    $display("FAIL %s din pix%0d got=%h exp=%h",
                             name, k, bus.din, 8'(color));
                end
                checks++;
                if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s rdy/busy pix%0d got=%b%b exp=01",
                             name, k, bus.cmd_ready, bus.busy);
                end
            end else begin
                checks++;
                if (bus.wen !== 1'b0) begin
                    failures++;
                    $display("FAIL %s wen tail%0d got=%b exp=0", name, k, bus.wen);
                end
                checks++;
                if (bus.cmd_ready !== (k == tail)) begin
                    failures++;
                    $display("FAIL %s ready tail%0d got=%b exp=%b",
                             name, k, bus.cmd_ready, k == tail);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.wen, bus.swap_buf, bus.busy} !== 4'b0 ||
            bus.mem_addr !== '0 || bus.din !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b addr=%0d din=%h exp=0",
                     bus.cmd_ready, bus.wen, bus.swap_buf, bus.busy,
                     bus.mem_addr, bus.din);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.cmd_ready);
        end
    endtask

    task automatic test_fill_directed();
        do_fill("fill_1x1", 0, 0, 1, 1, 'h3F);
        do_fill("fill_3x2", 10, 2, 3, 2, 'h30);
        do_fill("fill_edge", 318, 239, 5, 5, 'h15);
        do_fill("fill_zero", 4, 4, 0, 7, 'h2A);
    endtask

    task automatic test_fill_random();
        for (int i = 0; i < 25; i++)
            do_fill("fill_rand", $urandom_range(340), $urandom_range(250),
                    $urandom_range(9), $urandom_range(6), $urandom_range(63));
    endtask

    task automatic present(input string name, input int low_cyc, input int high_cyc);
        send_cmd(1'b1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checks++;
        if (bus.swap_buf !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s swap_on got=%b%b exp=10", name,
                     bus.swap_buf, bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.swap_buf !== 1'b0) begin
            failures++;
            $display("FAIL %s swap_off got=%b exp=0", name, bus.swap_buf);
        end
        repeat (low_cyc) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL %s wait_low got=%b%b exp=01", name,
                         bus.cmd_ready, bus.busy);
            end
        end
        @(negedge clk);
        bus.v_sync = 1'b1;
        repeat (high_cyc) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.cmd_ready !== 1'b0 || bus.swap_buf !== 1'b0) begin
                failures++;
                $display("FAIL %s wait_high got=%b%b exp=00", name,
                         bus.cmd_ready, bus.swap_buf);
            end
        end
        @(negedge clk);
        bus.v_sync = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_fall got=%b%b exp=10", name,
                     bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_present();
        @(negedge clk);
        bus.v_sync = 1'b0;
        repeat (3) @(negedge clk);
        present("present_low", 6, 5);
        @(negedge clk);
        bus.v_sync = 1'b1;
        repeat (2) @(negedge clk);
        present("present_high", 0, 4);
        @(negedge clk);
        bus.v_sync = 1'b1;
    endtask

    task automatic test_reset_mid_fill();
        send_cmd(1'b0, 0, 0, 10, 10, 'h0C);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.wen !== 1'b1 || bus.mem_addr !== AW'(3)) begin
            failures++;
            $display("FAIL midrst_pix4 got=%b/%0d exp=1/3", bus.wen, bus.mem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.wen, bus.busy, bus.cmd_ready, bus.swap_buf} !== 4'b0 ||
            bus.mem_addr !== '0) begin
            failures++;
            $display("FAIL midrst_async got=%b%b%b%b addr=%0d exp=0",
                     bus.wen, bus.busy, bus.cmd_ready, bus.swap_buf, bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.wen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release got=%b%b exp=10", bus.cmd_ready, bus.wen);
        end
        do_fill("fill_after_rst", 7, 3, 4, 3, 'h21);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        bus.v_sync    = 1'b1;
        test_reset();
        test_fill_directed();
        test_fill_random();
        test_present();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
